// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg
// Shared definitions for the program loader: the loader state encoding and
// the CRC-8 constants used when CRC checking is built in
// (PROG_LOADER_CRC_EN).
// No ports; imported by prog_loader and crc8_update.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        READY = 3'd3,
        FAIL  = 3'd4
    } state_e;

    // CRC-8: x^8 + x^2 + x + 1, zero init, no reflection, no final XOR.
    localparam logic [7:0] CRC_POLY = 8'h07;
    localparam logic [7:0] CRC_INIT = 8'h00;

endpackage

// File: rtl/prog_loader_crc8_update.sv
// crc8_update
// Purely combinational CRC-8 step: folds one beat of INPUT_WIDTH bits into a
// running CRC, MSB of the beat first.
// Ports:
//   crc_i  [7:0]             current CRC value
//   beat_i [INPUT_WIDTH-1:0] beat payload
//   crc_o  [7:0]             CRC after absorbing the beat
module crc8_update
    import prog_loader_pkg::*;
#(
    parameter int INPUT_WIDTH = 1
) (
    input  logic [7:0]             crc_i,
    input  logic [INPUT_WIDTH-1:0] beat_i,
    output logic [7:0]             crc_o
);

    logic [7:0] crcWork;
    logic       feedback;

    // Unrolled bit-serial LFSR: one shift per payload bit, MSB first.
    always_comb begin
        crcWork  = crc_i;
        feedback = 1'b0;
        for (int i = INPUT_WIDTH - 1; i >= 0; i--) begin
            feedback = crcWork[7] ^ beat_i[i];
            crcWork  = {crcWork[6:0], 1'b0};
            if (feedback) begin
                crcWork = crcWork ^ CRC_POLY;
            end
        end
        crc_o = crcWork;
    end

endmodule

// File: rtl/prog_loader.sv
// prog_loader
// Streams a program image into a downstream shift register, one beat of
// INPUT_WIDTH bits per accepted handshake, and flags when the program is
// complete. With PROG_LOADER_CRC_EN defined, the image is followed by an
// 8-bit CRC trailer that must match before the program is marked runnable.
// Ports:
//   clock        rising-edge clock
//   rst_n        synchronous active-low reset
//   start        begin / restart a load (beat in the same cycle is dropped)
//   in_valid     beat on in_data is valid
//   in_data      beat payload
//   in_ready     loader accepts a beat this cycle
//   prog_enable  shift strobe to the program shift register
//   prog_data    shift data to the program shift register
//   run_enable   program is valid and may execute
//   busy/done/error  status: loading or checking / ready / CRC mismatch
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int MEM_WIDTH   = 263,
    parameter int INPUT_WIDTH = 1
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [INPUT_WIDTH-1:0] in_data,
    output logic                   in_ready,
    output logic                   prog_enable,
    output logic [INPUT_WIDTH-1:0] prog_data,
    output logic                   run_enable,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    localparam int CHUNKS   = (MEM_WIDTH + INPUT_WIDTH - 1) / INPUT_WIDTH;
    localparam int CNT_BASE = $clog2(CHUNKS + 1);

`ifdef PROG_LOADER_CRC_EN
    localparam int TRAILER_BEATS = 8 / INPUT_WIDTH;
    // The same counter also walks the trailer, so it must reach 8 even for
    // very short images.
    localparam int CNT_W = (CNT_BASE > 4) ? CNT_BASE : 4;
    localparam logic [CNT_W-1:0] LAST_TRAILER = CNT_W'(TRAILER_BEATS - 1);
`else
    localparam int CNT_W = CNT_BASE;
`endif

    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(CHUNKS - 1);

    state_e           state_q;
    logic [CNT_W-1:0] count_q;

`ifdef PROG_LOADER_CRC_EN
    logic [7:0] crc_q;
    logic [7:0] crc_d;
    logic [7:0] trailer_q;
    logic [7:0] trailer_d;

    crc8_update #(
        .INPUT_WIDTH(INPUT_WIDTH)
    ) u_crc8_update (
        .crc_i  (crc_q),
        .beat_i (in_data),
        .crc_o  (crc_d)
    );

    // Trailer arrives MSB-first; older beats move toward bit 7.
    assign trailer_d = 8'({trailer_q, in_data});
`endif

    // Start outranks everything except reset; a beat coinciding with start
    // is never accepted because in_ready is masked by start.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
`ifdef PROG_LOADER_CRC_EN
            crc_q     <= CRC_INIT;
            trailer_q <= '0;
`endif
        end else if (start) begin
            state_q   <= LOAD;
            count_q   <= '0;
`ifdef PROG_LOADER_CRC_EN
            crc_q     <= CRC_INIT;
            trailer_q <= '0;
`endif
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_valid) begin
                        count_q <= count_q + CNT_W'(1);
`ifdef PROG_LOADER_CRC_EN
                        crc_q   <= crc_d;
                        if (count_q == LAST_CHUNK) begin
                            state_q <= CHECK;
                            count_q <= '0;
                        end
`else
                        if (count_q == LAST_CHUNK) begin
                            state_q <= READY;
                        end
`endif
                    end
                end
`ifdef PROG_LOADER_CRC_EN
                CHECK: begin
                    if (in_valid) begin
                        trailer_q <= trailer_d;
                        count_q   <= count_q + CNT_W'(1);
                        if (count_q == LAST_TRAILER) begin
                            state_q <= (trailer_d == crc_q) ? READY : FAIL;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign busy        = (state_q == LOAD) || (state_q == CHECK);
    assign in_ready    = busy && !start;
    assign prog_enable = in_valid && in_ready && (state_q == LOAD);
    assign prog_data   = in_data;
    assign done        = (state_q == READY);
    assign run_enable  = (state_q == READY);
`ifdef PROG_LOADER_CRC_EN
    assign error       = (state_q == FAIL);
`else
    assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
// Drives two loader instances (12-bit image in 4-bit beats, and the default
// 263-bit image in 1-bit beats) with directed scenarios followed by random
// traffic, comparing every output each cycle against a behavioural model of
// the load protocol. Builds with or without PROG_LOADER_CRC_EN.
module tb_prog_loader;

    localparam int W_A   = 4;
    localparam int MEM_A = 12;
    localparam int W_B   = 1;
    localparam int MEM_B = 263;

`ifdef PROG_LOADER_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic clock = 1'b0;
    logic rst_n;

    logic           startA, validA;
    logic [W_A-1:0] dataA;
    logic           readyA, enA, runA, busyA, doneA, errA;
    logic [W_A-1:0] pdataA;

    logic           startB, validB;
    logic [W_B-1:0] dataB;
    logic           readyB, enB, runB, busyB, doneB, errB;
    logic [W_B-1:0] pdataB;

    int checks = 0;
    int errors = 0;

    // Model state per instance: phase 0 idle, 1 loading, 2 checking trailer,
    // 3 ready, 4 failed.
    int phase[2];
    int beats[2];
    int crcM[2];
    int trailerM[2];
    int pulses[2];
    int widthOf[2]  = '{W_A, W_B};
    int chunksOf[2] = '{(MEM_A + W_A - 1) / W_A, (MEM_B + W_B - 1) / W_B};

    always #5 clock = ~clock;

    prog_loader #(.MEM_WIDTH(MEM_A), .INPUT_WIDTH(W_A)) dutA (
        .clock(clock), .rst_n(rst_n), .start(startA), .in_valid(validA),
        .in_data(dataA), .in_ready(readyA), .prog_enable(enA),
        .prog_data(pdataA), .run_enable(runA), .busy(busyA), .done(doneA),
        .error(errA)
    );

    prog_loader #(.MEM_WIDTH(MEM_B), .INPUT_WIDTH(W_B)) dutB (
        .clock(clock), .rst_n(rst_n), .start(startB), .in_valid(validB),
        .in_data(dataB), .in_ready(readyB), .prog_enable(enB),
        .prog_data(pdataB), .run_enable(runB), .busy(busyB), .done(doneB),
        .error(errB)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // One bit of CRC-8 (poly 0x07) long division, done on plain integers.
    function automatic int crcBit(input int c, input int b);
        int fb;
        fb = ((c >> 7) & 1) ^ (b & 1);
        c  = (c << 1) & 255;
        if (fb != 0) c = c ^ 7;
        return c;
    endfunction

    // Expected outputs follow from the current phase and this cycle's inputs.
    task automatic expectOutputs(input int id, input string nm, input logic s,
                                 input logic v, input int d, input logic oRdy,
                                 input logic oEn, input int oData,
                                 input logic oRun, input logic oBusy,
                                 input logic oDone, input logic oErr);
        bit active, rdy;
        active = (phase[id] == 1) || (phase[id] == 2);
        rdy    = active && !s;
        checkOutput({nm, "_in_ready"},    32'(oRdy),  32'(rdy));
        checkOutput({nm, "_prog_enable"}, 32'(oEn),   32'(v && rdy && phase[id] == 1));
        checkOutput({nm, "_prog_data"},   32'(oData), 32'(d));
        checkOutput({nm, "_busy"},        32'(oBusy), 32'(active));
        checkOutput({nm, "_done"},        32'(oDone), 32'(phase[id] == 3));
        checkOutput({nm, "_run_enable"},  32'(oRun),  32'(phase[id] == 3));
        checkOutput({nm, "_error"},       32'(oErr),  32'(phase[id] == 4));
    endtask

    // Advance the protocol model by one clock edge.
    task automatic modelUpdate(input int id, input logic rstv, input logic s,
                               input logic v, input int d);
        int w;
        w = widthOf[id];
        if (!rstv || s) begin
            phase[id]    = rstv ? 1 : 0;
            beats[id]    = 0;
            crcM[id]     = 0;
            trailerM[id] = 0;
        end else if (v && phase[id] == 1) begin
            for (int i = w - 1; i >= 0; i--) crcM[id] = crcBit(crcM[id], d >> i);
            beats[id]++;
            if (beats[id] == chunksOf[id]) begin
                phase[id] = CRC_ON ? 2 : 3;
                beats[id] = 0;
            end
        end else if (v && phase[id] == 2) begin
            trailerM[id] = ((trailerM[id] << w) | d) & 255;
            beats[id]++;
            if (beats[id] == 8 / w) phase[id] = (trailerM[id] == crcM[id]) ? 3 : 4;
        end
    endtask

    // One clock: drive both instances, check outputs mid-cycle, step the model.
    task automatic applyStimulus(input logic rstv, input logic sA, input logic vA,
                                 input int dA, input logic sB, input logic vB,
                                 input int dB);
        rst_n  = rstv;
        startA = sA; validA = vA; dataA = W_A'(dA);
        startB = sB; validB = vB; dataB = W_B'(dB);
        #1;
        expectOutputs(0, "A", sA, vA, dA & 15, readyA, enA, int'(pdataA), runA, busyA, doneA, errA);
        expectOutputs(1, "B", sB, vB, dB & 1,  readyB, enB, int'(pdataB), runB, busyB, doneB, errB);
        if (enA) pulses[0]++;
        if (enB) pulses[1]++;
        @(posedge clock);
        modelUpdate(0, rstv, sA, vA, dA & 15);
        modelUpdate(1, rstv, sB, vB, dB & 1);
        @(negedge clock);
    endtask

    task automatic cycA(input logic s, input logic v, input int d);
        applyStimulus(1'b1, s, v, d, 1'b0, 1'b0, 0);
    endtask

    initial begin
        int c;
        rst_n = 1'b0; startA = 1'b0; validA = 1'b0; dataA = '0;
        startB = 1'b0; validB = 1'b0; dataB = '0;
        for (int i = 0; i < 2; i++) begin
            phase[i] = 0; beats[i] = 0; crcM[i] = 0; trailerM[i] = 0; pulses[i] = 0;
        end
        repeat (2) @(posedge clock);
        @(negedge clock);

        // Reset state, then idle with in_valid high must stay idle.
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
        cycA(1'b0, 1'b1, 5);
        checkOutput("reset_busy", 32'(busyA), 32'd0);

        // Continuous beats A, B, C.
        pulses[0] = 0;
        cycA(1'b1, 1'b0, 0);
        cycA(1'b0, 1'b1, 4'hA);
        cycA(1'b0, 1'b1, 4'hB);
        cycA(1'b0, 1'b1, 4'hC);
        checkOutput("t1_pulses", 32'(pulses[0]), 32'd3);
        checkOutput("t1_done",   32'(doneA),     CRC_ON ? 32'd0 : 32'd1);
        checkOutput("t1_run",    32'(runA),      CRC_ON ? 32'd0 : 32'd1);
        cycA(1'b0, 1'b0, 0);

        // Gapped valid 1,0,1,0,1.
        pulses[0] = 0;
        cycA(1'b1, 1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t2_busy", 32'(busyA), 32'd1);
            cycA(1'b0, (i % 2) == 0, $urandom_range(0, 15));
        end
        checkOutput("t2_pulses", 32'(pulses[0]), 32'd3);
        checkOutput("t2_done",   32'(doneA),     CRC_ON ? 32'd0 : 32'd1);

        // Restart after two beats, with a valid beat in the start cycle.
        pulses[0] = 0;
        cycA(1'b1, 1'b0, 0);
        cycA(1'b0, 1'b1, 1);
        cycA(1'b0, 1'b1, 2);
        cycA(1'b1, 1'b1, 3);
        checkOutput("t3_pulses_restart", 32'(pulses[0]), 32'd2);
        cycA(1'b0, 1'b1, 4);
        cycA(1'b0, 1'b1, 5);
        checkOutput("t3_done_early", 32'(doneA), 32'd0);
        cycA(1'b0, 1'b1, 6);
        checkOutput("t3_pulses", 32'(pulses[0]), 32'd5);
        checkOutput("t3_done",   32'(doneA),     CRC_ON ? 32'd0 : 32'd1);

        // Reset for one cycle mid-load, then in_valid is ignored.
        cycA(1'b1, 1'b0, 0);
        cycA(1'b0, 1'b1, 7);
        applyStimulus(1'b0, 1'b0, 1'b1, 8, 1'b0, 1'b0, 0);
        pulses[0] = 0;
        repeat (4) cycA(1'b0, 1'b1, 9);
        checkOutput("t4_pulses", 32'(pulses[0]), 32'd0);
        checkOutput("t4_busy",   32'(busyA),     32'd0);

`ifdef PROG_LOADER_CRC_EN
        // Zero image with matching and mismatching trailers.
        cycA(1'b1, 1'b0, 0);
        repeat (3) cycA(1'b0, 1'b1, 0);
        cycA(1'b0, 1'b1, 0);
        cycA(1'b0, 1'b1, 0);
        checkOutput("t5_done",  32'(doneA), 32'd1);
        checkOutput("t5_error", 32'(errA),  32'd0);
        cycA(1'b1, 1'b0, 0);
        repeat (3) cycA(1'b0, 1'b1, 0);
        cycA(1'b0, 1'b1, 0);
        cycA(1'b0, 1'b1, 1);
        checkOutput("t6_error", 32'(errA), 32'd1);
        checkOutput("t6_run",   32'(runA), 32'd0);
`endif

        // Full-size serial image on instance B.
        pulses[1] = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 0);
        for (int i = 0; i < MEM_B; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, $urandom_range(0, 1));
        checkOutput("t7_pulses", 32'(pulses[1]), 32'd263);
        c = crcM[1];
        for (int i = 7; i >= 0; i--)
            applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, (c >> i) & 1);
        checkOutput("t7_done",   32'(doneB),     32'd1);
        checkOutput("t7_pulses_after", 32'(pulses[1]), 32'd263);

        // Random traffic on both instances.
        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(0, 199) != 0,
                          $urandom_range(0, 14) == 0, $urandom_range(0, 2) != 0,
                          $urandom_range(0, 15),
                          $urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
